// File: rtl/dio_sdram_bridge_pkg.sv
// Shared types and constants for the data_io -> SDRAM download bridge.
package dio_sdram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE
    } bridge_state_t;

    // FIFO entry is {addr[13:0], data[7:0]}
    localparam int          ENTRY_W      = 22;
    localparam logic [15:0] DEF_ROM_BASE = 16'hC000;

endpackage

// File: rtl/dio_sdram_bridge_fifo.sv
// Small synchronous register FIFO buffering download bytes ahead of the SDRAM writer.
module dio_fifo
    import dio_sdram_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // A push accompanying a flush becomes the sole entry of the emptied FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(push);
            count  <= (AW+1)'(push);
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[flush ? '0 : wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/dio_sdram_bridge.sv
// Streams data_io ROM download bytes into SDRAM; passes CPU requests through when idle.
module dio_sdram_bridge
    import dio_sdram_bridge_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter int          WR_HOLD    = 2,
    parameter logic [15:0] ROM_BASE   = DEF_ROM_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dio_download,
    input  logic        dio_write,
    input  logic [24:0] dio_addr,
    input  logic [7:0]  dio_data,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_we,
    input  logic        cpu_oe,
    output logic [24:0] sd_addr,
    output logic [7:0]  sd_din,
    output logic        sd_we,
    output logic        sd_oe,
    output logic        busy,
    output logic        rom_loaded,
    output logic [15:0] byte_count,
    output logic        overflow
);

    localparam int HW = $clog2(WR_HOLD) + 1;

    bridge_state_t state, state_nxt;

    logic [ENTRY_W-1:0]           head;
    logic [13:0]                  ent_addr;
    logic [7:0]                   ent_data;
    logic [HW-1:0]                hold_cnt;
    logic                         dl_q;
    logic                         clr_pend;
    logic                         loaded_q;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;

    logic dl_rise, is_idle, do_clear, pop, push, drop, write_done, load_done;
    logic unused_addr_hi;

    assign unused_addr_hi = ^dio_addr[24:14];

    assign dl_rise    = dio_download & ~dl_q;
    assign is_idle    = (state == ST_IDLE);
    // A new download only resets bookkeeping once the in-flight byte has landed
    assign do_clear   = (dl_rise | clr_pend) & is_idle;
    assign pop        = is_idle & ~fifo_empty & ~do_clear;
    assign push       = dio_write & (do_clear | ~fifo_full | pop);
    assign drop       = dio_write & fifo_full & ~pop & ~do_clear;
    assign write_done = (state == ST_WRITE) && (hold_cnt == HW'(WR_HOLD - 1));

    assign busy       = dio_download | (fifo_count != '0) | ~is_idle;
    assign load_done  = ~dio_download & fifo_empty & is_idle & (byte_count != '0) & ~overflow;
    // Combinational term lets rom_loaded rise in the same cycle busy falls
    assign rom_loaded = loaded_q | load_done;

    dio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (do_clear),
        .push  (push),
        .pop   (pop),
        .din   ({dio_addr[13:0], dio_data}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pop) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_WRITE;
            ST_WRITE: if (write_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            ent_addr   <= '0;
            ent_data   <= '0;
            dl_q       <= 1'b0;
            clr_pend   <= 1'b0;
            byte_count <= '0;
            overflow   <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dl_q     <= dio_download;
            clr_pend <= (dl_rise | clr_pend) & ~is_idle;
            hold_cnt <= (state == ST_WRITE) ? hold_cnt + 1'b1 : '0;
            if (pop) {ent_addr, ent_data} <= head;

            if (do_clear)        byte_count <= '0;
            else if (write_done) byte_count <= byte_count + 1'b1;

            if (do_clear)  overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;

            if (do_clear)       loaded_q <= 1'b0;
            else if (load_done) loaded_q <= 1'b1;
        end
    end

    always_comb begin
        if (!busy) begin
            sd_addr = {9'd0, cpu_addr};
            sd_din  = cpu_din;
            sd_we   = cpu_we;
            sd_oe   = cpu_oe;
        end else begin
            sd_addr = {9'd0, ROM_BASE[15:14], ent_addr};
            sd_din  = ent_data;
            sd_we   = (state == ST_WRITE);
            sd_oe   = ~is_idle;
        end
    end

endmodule
